// File: rtl/alarm.sv
// Home-security alarm controller: synchronizes six raw switch/sensor pins, debounces
// sensor breaches while armed, and drives a registered siren output with zone memory.
module alarm #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter bit LATCH       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PANIC,
    input  logic       ENABLE,
    input  logic       EXITING,
    input  logic       WINDOW,
    input  logic       DOOR,
    input  logic       GARAGE,
    output logic       ALARM,
    output logic       ARMED,
    output logic [2:0] ZONE
);

    localparam int              CNT_W    = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(DEBOUNCE - 1);
    // Idle pin levels: controls released, every sensor closed.
    localparam logic [5:0]       SYNC_RST = 6'b000111;

    logic [5:0]       raw;
    logic [5:0]       sync_p0 [SYNC_STAGES];
    logic [5:0]       in_s;
    logic             panic_s;
    logic             enable_s;
    logic             exiting_s;
    logic [2:0]       sense_s;
    logic [CNT_W-1:0] cnt_p1;
    logic             breach;
    logic             intrusion;
    logic             set_cond;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign raw = {PANIC, ENABLE, EXITING, WINDOW, DOOR, GARAGE};

    // Stage p0: synchronizer chain on every pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_p0[i] <= SYNC_RST;
        end else begin
            sync_p0[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p0[i] <= sync_p0[i-1];
        end
    end

    assign in_s      = sync_p0[SYNC_STAGES-1];
    assign panic_s   = in_s[5];
    assign enable_s  = in_s[4];
    assign exiting_s = in_s[3];
    assign sense_s   = in_s[2:0];

    assign breach    = enable_s & ~exiting_s & ~(&sense_s);
    assign intrusion = breach & (cnt_p1 >= CNT_TRIP);
    assign set_cond  = panic_s | intrusion;

    // Stage p1: debounce counter, siren, armed status and zone memory
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p1 <= '0;
            ALARM  <= 1'b0;
            ARMED  <= 1'b0;
            ZONE   <= 3'b000;
        end else begin
            cnt_p1 <= breach ? sat_inc(cnt_p1) : '0;
            ARMED  <= enable_s & ~exiting_s;
            if (LATCH) begin
                // Set beats disarm, so a held panic keeps the siren on while disarmed.
                if (set_cond)
                    ALARM <= 1'b1;
                else if (!enable_s && !panic_s)
                    ALARM <= 1'b0;
            end else begin
                ALARM <= set_cond;
            end
            if (!enable_s)
                ZONE <= 3'b000;
            else if (intrusion)
                ZONE <= ZONE | ~sense_s;
        end
    end

endmodule

// File: tb/tb_alarm.sv
// Scoreboard bench for alarm: latched and live variants driven in parallel and
// checked every cycle against a pin-history reference model.
module tb_alarm;
    localparam int         SYNC = 2;
    localparam int         DEB  = 4;
    localparam logic [5:0] DEF  = 6'b000111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       PANIC = 1'b0, ENABLE = 1'b0, EXITING = 1'b0;
    logic       WINDOW = 1'b1, DOOR = 1'b1, GARAGE = 1'b1;
    logic       alarm1, armed1, alarm0, armed0;
    logic [2:0] zone1, zone0;

    typedef struct packed {
        logic       a1;
        logic       a0;
        logic       armed;
        logic [2:0] zone;
    } exp_t;

    exp_t       sbq[$];
    logic [5:0] hist[$];
    int         brun;
    logic       m_a1, m_a0, m_armed;
    logic [2:0] m_zone;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    alarm #(.SYNC_STAGES(SYNC), .DEBOUNCE(DEB), .LATCH(1'b1)) u_latch (
        .clk(clk), .rst(rst), .PANIC(PANIC), .ENABLE(ENABLE), .EXITING(EXITING),
        .WINDOW(WINDOW), .DOOR(DOOR), .GARAGE(GARAGE),
        .ALARM(alarm1), .ARMED(armed1), .ZONE(zone1));

    alarm #(.SYNC_STAGES(SYNC), .DEBOUNCE(DEB), .LATCH(1'b0)) u_live (
        .clk(clk), .rst(rst), .PANIC(PANIC), .ENABLE(ENABLE), .EXITING(EXITING),
        .WINDOW(WINDOW), .DOOR(DOOR), .GARAGE(GARAGE),
        .ALARM(alarm0), .ARMED(armed0), .ZONE(zone0));

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the logic sees each pin SYNC edges late; an intrusion is a breach
    // that has been present on the last DEB consecutive edges.
    task automatic step(input logic [5:0] v, input logic r);
        exp_t       e;
        logic [5:0] s;
        int         idx;
        logic       pan, en, ex, b, intr;
        rst = r;
        {PANIC, ENABLE, EXITING, WINDOW, DOOR, GARAGE} = v;
        if (r) begin
            hist.delete();
            brun    = 0;
            m_a1    = 1'b0;
            m_a0    = 1'b0;
            m_armed = 1'b0;
            m_zone  = 3'b000;
        end else begin
            idx = hist.size() - SYNC;
            s = DEF;
            if (idx >= 0) s = hist[idx];
            hist.push_back(v);
            pan  = s[5];
            en   = s[4];
            ex   = s[3];
            b    = en && !ex && (s[2:0] != 3'b111);
            brun = b ? brun + 1 : 0;
            intr = b && (brun >= DEB);
            if (pan || intr) m_a1 = 1'b1;
            else if (!en)    m_a1 = 1'b0;
            m_a0    = pan || intr;
            m_armed = en && !ex;
            if (!en)       m_zone = 3'b000;
            else if (intr) m_zone = m_zone | ~s[2:0];
        end
        e.a1 = m_a1; e.a0 = m_a0; e.armed = m_armed; e.zone = m_zone;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) step(v, 1'b0);
    endtask

    task automatic async_reset(input logic [5:0] v);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_alarm", alarm1, 0);
        chk("async_rst_armed", armed1, 0);
        chk("async_rst_zone", zone1, 0);
        step(v, 1'b1);
        step(v, 1'b0);
    endtask

    // Monitor: every edge presents a new output word
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sb_alarm_latch", alarm1, e.a1);
                chk("sb_alarm_live", alarm0, e.a0);
                chk("sb_armed", armed1, e.armed);
                chk("sb_zone", zone1, e.zone);
                chk("sb_armed_live", armed0, e.armed);
                chk("sb_zone_live", zone0, e.zone);
            end
        end
    end

    initial begin
        logic [5:0] v;
        int         n;
        #1;
        chk("reset_alarm", alarm1, 0);
        chk("reset_armed", armed1, 0);
        chk("reset_zone", zone1, 0);
        @(negedge clk);
        step(DEF, 1'b1);
        step(DEF, 1'b0);

        // exiting: breach ignored
        hold(6'b011101, 20);
        chk("exit_alarm", alarm1, 0);
        chk("exit_armed", armed1, 0);
        chk("exit_zone", zone1, 0);
        // exit ends with door open: alarm on the sixth edge
        hold(6'b010101, 5);
        chk("door_pre_alarm", alarm1, 0);
        hold(6'b010101, 1);
        chk("door_alarm", alarm1, 1);
        chk("door_zone", zone1, 3'b010);
        chk("door_armed", armed1, 1);
        // door closes: latched holds, live drops after three edges
        hold(6'b010111, 3);
        chk("close_latch", alarm1, 1);
        chk("close_live", alarm0, 0);
        hold(6'b000111, 3);
        chk("disarm_alarm", alarm1, 0);
        chk("disarm_zone", zone1, 0);
        // window intrusion
        hold(6'b010111, 5);
        hold(6'b010011, 5);
        chk("win_pre_alarm", alarm1, 0);
        hold(6'b010011, 1);
        chk("win_alarm", alarm1, 1);
        chk("win_zone", zone1, 3'b100);
        // panic while disarmed
        hold(6'b000111, 4);
        hold(6'b100111, 2);
        chk("panic_pre", alarm1, 0);
        hold(6'b100111, 1);
        chk("panic_alarm", alarm1, 1);
        chk("panic_zone", zone1, 0);
        hold(6'b100111, 3);
        hold(6'b000111, 2);
        chk("panic_release_hold", alarm1, 1);
        hold(6'b000111, 1);
        chk("panic_release", alarm1, 0);
        // short garage glitch, then a real one and a mid-alarm reset
        hold(6'b010111, 4);
        hold(6'b010110, 3);
        hold(6'b010111, 6);
        chk("glitch_alarm", alarm1, 0);
        chk("glitch_zone", zone1, 0);
        hold(6'b010110, 8);
        chk("garage_alarm", alarm1, 1);
        chk("garage_zone", zone1, 3'b001);
        async_reset(6'b010110);

        // randomized: held levels of random length, occasional reset
        for (int i = 0; i < 400; i++) begin
            v = 6'($urandom);
            if ($urandom_range(0, 3) != 0) v[5] = 1'b0;
            if ($urandom_range(0, 2) != 0) v[3] = 1'b0;
            if ($urandom_range(0, 1) != 0) v[2:0] = 3'b111;
            n = $urandom_range(1, 8);
            hold(v, n);
            if ($urandom_range(0, 60) == 0) async_reset(v);
        end

        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alarm.md
Name: alarm

Overview:
Home-security alarm controller. Six asynchronous, level-sensitive control and sensor inputs pass through a synchronizer, then debounce and arming logic, and drive one registered ALARM output plus status. It sits between raw switch/sensor pins and the siren driver, in a single clock domain. The asynchronous reset is active-high.

Parameters:
SYNC_STAGES, 2, number of flip-flop stages on every input synchronizer (minimum 2).
DEBOUNCE, 4, consecutive cycles a qualified breach must persist before intrusion is declared (minimum 1).
LATCH, 1, 1 = ALARM holds until disarm; 0 = ALARM tracks the live condition.

Ports:
clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous active-high reset.
PANIC  input  1  panic button; 1 = panic.
ENABLE  input  1  system armed request; 1 = enabled.
EXITING  input  1  occupant exiting; 1 = sensor breaches ignored.
WINDOW  input  1  window sensor; 1 = closed/secure, 0 = open.
DOOR  input  1  door sensor; 1 = closed/secure, 0 = open.
GARAGE  input  1  garage sensor; 1 = closed/secure, 0 = open.
ALARM  output  1  siren drive; 1 = alarm active.
ARMED  output  1  ENABLE_s and not EXITING_s (registered).
ZONE  output  3  tripped-zone memory: bit 2 = WINDOW, bit 1 = DOOR, bit 0 = GARAGE.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - synchronizer stages: PANIC/ENABLE/EXITING = 0; WINDOW/DOOR/GARAGE = 1 (secure).
  - debounce counter = 0; ALARM = 0; ARMED = 0; ZONE = 000.
- Synchronization: each input goes through SYNC_STAGES flops. Signals with suffix _s denote the synchronizer outputs.
- breach = ENABLE_s and not EXITING_s and not (WINDOW_s and DOOR_s and GARAGE_s).
- Debounce counter:
  - saturating; counts 0..DEBOUNCE.
  - increments each edge while breach = 1; clears to 0 on any edge with breach = 0.
  - intrusion = breach and (counter >= DEBOUNCE-1).
- set_cond = PANIC_s or intrusion. PANIC bypasses ENABLE, EXITING and the debounce.
- ALARM register:
  - LATCH=1: ALARM <= 1 when set_cond; ALARM <= 0 only on an edge where ENABLE_s = 0 and PANIC_s = 0 (disarm); otherwise it holds.
  - LATCH=0: ALARM <= set_cond every edge.
- Latency in rising edges from an input change to ALARM rise:
  - panic: SYNC_STAGES+1.
  - intrusion: SYNC_STAGES+DEBOUNCE.
- Equivalent steady-state function (LATCH=0): ALARM = PANIC | (ENABLE & ~EXITING & ~(WINDOW & DOOR & GARAGE)).
- ZONE:
  - On any edge where intrusion = 1, ZONE <= ZONE | {~WINDOW_s, ~DOOR_s, ~GARAGE_s}.
  - Cleared to 000 on any edge with ENABLE_s = 0.
  - Panic never sets ZONE bits.
- ARMED <= ENABLE_s & ~EXITING_s every edge.
- Simultaneous events:
  - Disarm and set_cond on the same edge: set_cond wins, so ALARM = 1. This applies only while PANIC_s is held; with ENABLE_s = 0 only panic can set.
  - ZONE clear and ZONE set on the same edge cannot coincide, because intrusion requires ENABLE_s = 1.
- EXITING rising while a breach is being debounced clears the counter; no alarm results.
- A breach that disappears before DEBOUNCE cycles produces no alarm and no ZONE bits.

Test Plan:
1. Defaults (SYNC_STAGES=2, DEBOUNCE=4, LATCH=1). Hold PANIC=0, ENABLE=1, EXITING=1, WINDOW=1, DOOR=0, GARAGE=1 for 20 cycles -> ALARM=0, ARMED=0, ZONE=000.
2. From case 1, drop EXITING to 0 -> ARMED=1 after 3 edges; ALARM=1 exactly 6 edges after the change; ZONE=010.
3. Raise DOOR to 1 (all closed) -> with LATCH=1, ALARM stays 1. Then set ENABLE=0 -> ALARM=0 and ZONE=000 three edges later. With LATCH=0, ALARM=0 three edges after DOOR rises.
4. Re-arm with ENABLE=1, EXITING=0, all sensors closed; then drop WINDOW to 0 -> ALARM=1 after 6 edges; ZONE=100.
5. ENABLE=0, sensors closed; pulse PANIC=1 -> ALARM=1 after 3 edges, ZONE=000. Hold PANIC, then release it -> ALARM=0 on the following disarm edge.
6. Armed; open GARAGE for 3 cycles only -> ALARM stays 0. Also assert rst mid-alarm -> ALARM, ARMED and ZONE read 0 immediately, without waiting for a clock edge.
